// File: rtl/spi_arb_pkg.sv
// ============================================================================
// spi_arb_pkg : shared types and helpers for the SPI transaction arbiter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;

  function automatic int timeout_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// ============================================================================
// rr_select : combinational round-robin picker, search begins at last_owner+1
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  int cand;

  // Offsets are visited in priority order; the first requesting slot wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_owner) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] && (cand == i)) begin
          winner[i] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_transaction_arbiter.sv
// ============================================================================
// spi_transaction_arbiter : round-robin sharing of one serial-out engine
// Optional watchdog enabled by macro SPI_ARB_TIMEOUT_EN (adds timeout_err)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_transaction_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          serial_start,
  output logic [DATA_WIDTH-1:0]         serial_data,
  input  logic                          serial_done,
  output logic                          busy
`ifdef SPI_ARB_TIMEOUT_EN
  , output logic                        timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_transaction_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t                state;
  logic [IDX_W-1:0]          last_owner;
  logic [IDX_W-1:0]          owner_idx;
  logic [NUM_REQ-1:0]        winner;
  logic                      win_valid;
  logic [DATA_WIDTH-1:0]     win_data;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wd_cnt;
`endif

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_comb begin
    win_data  = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (grant[i])  owner_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_owner   <= IDX_W'(NUM_REQ - 1);
      grant        <= '0;
      req_done     <= '0;
      serial_start <= 1'b0;
      serial_data  <= '0;
      busy         <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_cnt       <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      serial_start <= 1'b0;
      req_done     <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant        <= winner;
            serial_data  <= win_data;
            busy         <= 1'b1;
            serial_start <= 1'b1;
            state        <= START;
          end
        end
        START: begin
`ifdef SPI_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // Completion is reported to the owner even if it has dropped req.
          if (serial_done) begin
            req_done <= grant;
            state    <= DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_done    <= grant;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          last_owner <= owner_idx;
          grant      <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_transaction_arbiter.sv
// ============================================================================
// tb_spi_transaction_arbiter : vector table plus corner-case sequences
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_transaction_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [63:0] req_data;
  logic [1:0]  grant;
  logic [1:0]  req_done;
  logic        serial_start;
  logic [31:0] serial_data;
  logic        serial_done;
  logic        busy;
`ifdef SPI_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  spi_transaction_arbiter #(
    .NUM_REQ        (2),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .req_done     (req_done),
    .serial_start (serial_start),
    .serial_data  (serial_data),
    .serial_done  (serial_done),
`ifdef SPI_ARB_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;
  int double_start = 0;
  int overlap      = 0;
  bit prev_start   = 1'b0;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] d;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    int          delay;
    logic [1:0]  exp_grant;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (serial_start) seen = 1'b1;
    end
    check("start_seen", {31'd0, seen}, 32'd1);
  endtask

  // Engine completion pulse, then owner strobe and release one edge apart.
  task automatic do_done(input logic [1:0] exp_g);
    serial_done = 1'b1;
    step();
    serial_done = 1'b0;
    check("req_done_pulse", {30'd0, req_done}, {30'd0, exp_g});
    check("grant_in_done", {30'd0, grant}, {30'd0, exp_g});
    step();
    check("req_done_cleared", {30'd0, req_done}, 32'd0);
    check("grant_released", {30'd0, grant}, 32'd0);
    check("busy_released", {31'd0, busy}, 32'd0);
  endtask

  task automatic push(input logic [1:0] g, input logic [31:0] d);
    sb_t e;
    e.g = g;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = 2'b00;
    serial_done = 1'b0;
    sb_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (serial_start) begin
        if (prev_start) double_start++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: actual=start_pulse required=no_pulse");
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_grant", {30'd0, grant}, {30'd0, e.g});
          check("sb_data", serial_data, e.d);
        end
      end
      prev_start = serial_start;
      if (!$onehot0(grant) || (busy != (grant != 2'b00))) overlap++;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{2'b01, 32'h12345678, 32'h00000000, 40, 2'b01, 32'h12345678};
    vecs[1] = '{2'b11, 32'hA5A5A5A5, 32'h0F0F1234, 3,  2'b10, 32'h0F0F1234};
    vecs[2] = '{2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 1,  2'b01, 32'hDEADBEEF};
    vecs[3] = '{2'b01, 32'h00000001, 32'hFFFFFFFF, 7,  2'b01, 32'h00000001};
    vecs[4] = '{2'b11, 32'h11111111, 32'h80000000, 2,  2'b10, 32'h80000000};
    vecs[5] = '{2'b10, 32'h22222222, 32'h33333333, 5,  2'b10, 32'h33333333};
    vecs[6] = '{2'b11, 32'h44444444, 32'h55555555, 1,  2'b01, 32'h44444444};

    req_data = '0;
    apply_reset();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_req_done", {30'd0, req_done}, 32'd0);
    check("rst_start", {31'd0, serial_start}, 32'd0);
    check("rst_data", serial_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_ARB_TIMEOUT_EN
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif

    serial_done = 1'b1;
    step();
    serial_done = 1'b0;
    check("idle_done_ignored", {30'd0, req_done}, 32'd0);
    check("idle_done_no_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[k]) begin
      req_data = {vecs[k].d1, vecs[k].d0};
      req      = vecs[k].req;
      push(vecs[k].exp_grant, vecs[k].exp_data);
      wait_start();
      check("vec_grant", {30'd0, grant}, {30'd0, vecs[k].exp_grant});
      check("vec_data", serial_data, vecs[k].exp_data);
      check("vec_busy", {31'd0, busy}, 32'd1);
      repeat (vecs[k].delay) step();
      check("vec_grant_held", {30'd0, grant}, {30'd0, vecs[k].exp_grant});
      do_done(vecs[k].exp_grant);
      req = 2'b00;
      step();
    end
    check("data_held_idle", serial_data, 32'h44444444);

    // Both requesters hold req across completions: service must alternate.
    apply_reset();
    req_data = {32'hBBBB0001, 32'hAAAA0000};
    req      = 2'b11;
    for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 2'b01 : 2'b10,
                                     (i % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB0001);
    for (int i = 0; i < 4; i++) begin
      wait_start();
      check("fair_grant", {30'd0, grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
      repeat (4) step();
      do_done((i % 2 == 0) ? 2'b01 : 2'b10);
    end
    req = 2'b00;
    step();
    check("fair_sb_drained", sb_q.size(), 32'd0);

    // Done during START is ignored; dropping req in WAIT does not abort.
    req_data = {32'h0, 32'h5A5A0F0F};
    req      = 2'b01;
    push(2'b01, 32'h5A5A0F0F);
    wait_start();
    serial_done = 1'b1;
    step();
    serial_done = 1'b0;
    check("start_done_ignored", {30'd0, req_done}, 32'd0);
    req = 2'b00;
    repeat (3) step();
    check("early_release_busy", {31'd0, busy}, 32'd1);
    check("early_release_grant", {30'd0, grant}, 32'd1);
    do_done(2'b01);

    // Asynchronous reset in the middle of WAIT.
    req_data = {32'h0, 32'h77778888};
    req      = 2'b01;
    push(2'b01, 32'h77778888);
    wait_start();
    repeat (10) step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_grant", {30'd0, grant}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_data", serial_data, 32'd0);
    check("async_rst_start", {31'd0, serial_start}, 32'd0);
    req = 2'b00;
    sb_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    req_data = {32'h9999AAAA, 32'h0};
    req      = 2'b10;
    push(2'b10, 32'h9999AAAA);
    wait_start();
    check("post_rst_grant", {30'd0, grant}, 32'd2);
    repeat (2) step();
    do_done(2'b10);
    req = 2'b00;
    step();

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int  n;
      bit  seen;
      req_data = {32'h0, 32'hC0FFEE00};
      req      = 2'b01;
      push(2'b01, 32'hC0FFEE00);
      wait_start();
      n    = 0;
      seen = 1'b0;
      while (n < 25 && !seen) begin
        step();
        n++;
        if (req_done == 2'b01) seen = 1'b1;
      end
      check("timeout_done_seen", {31'd0, seen}, 32'd1);
      check("timeout_within_19", {31'd0, (n <= 19)}, 32'd1);
      check("timeout_err_set", {31'd0, timeout_err}, 32'd1);
      req = 2'b00;
      repeat (3) step();
      check("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
      check("timeout_grant_clear", {30'd0, grant}, 32'd0);
    end
`endif

    check("single_cycle_start", double_start, 32'd0);
    check("grant_onehot_busy", overlap, 32'd0);
    check("sb_all_consumed", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
